// File: rtl/router_sync.sv
// rtl/router_sync.sv - address latch, write steering and per-port timeout glue for the 1x3 router
//
// Sits between the router FSM and the three output FIFOs.
//   clock, reset                 : rising-edge clock, asynchronous active-high reset
//   detect_add, data_in[1:0]     : header strobe and destination address captured with it
//   write_enb_reg                : FSM write request for the current byte
//   read_enb_0..2                : per-port read strobes from the destinations
//   empty_0..2, full_0..2        : per-FIFO status flags
//   write_enb[2:0]               : one-hot FIFO write enable for the addressed port
//   fifo_full                    : full flag of the addressed FIFO (0 for address 3)
//   vld_out_0..2                 : port holds data (~empty)
//   soft_reset_0..2              : one-cycle flush pulse after TIMEOUT unread cycles
module router_sync #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

    logic [1:0]       addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       sr_q, sr_d;
    logic [2:0]       vld;
    logic [2:0]       rd;

    assign vld = ~{empty_2, empty_1, empty_0};
    assign rd  = {read_enb_2, read_enb_1, read_enb_0};

    assign vld_out_0 = vld[0];
    assign vld_out_1 = vld[1];
    assign vld_out_2 = vld[2];

    assign soft_reset_0 = sr_q[0];
    assign soft_reset_1 = sr_q[1];
    assign soft_reset_2 = sr_q[2];

    assign addr_d = detect_add ? data_in : addr_q;

    // Steering uses the registered address, so the header's own write
    // (one cycle after detect_add) already lands in the new FIFO.
    always_comb begin
        write_enb = 3'b000;
        if (write_enb_reg) begin
            case (addr_q)
                2'd0:    write_enb = 3'b001;
                2'd1:    write_enb = 3'b010;
                2'd2:    write_enb = 3'b100;
                default: write_enb = 3'b000;
            endcase
        end
    end

    always_comb begin
        case (addr_q)
            2'd0:    fifo_full = full_0;
            2'd1:    fifo_full = full_1;
            2'd2:    fifo_full = full_2;
            default: fifo_full = 1'b0;
        endcase
    end

    // A read on the terminal-count cycle takes priority and suppresses the pulse.
    always_comb begin
        sr_d = 3'b000;
        for (int n = 0; n < 3; n++) begin
            cnt_d[n] = cnt_q[n];
            if (!vld[n] || rd[n]) begin
                cnt_d[n] = '0;
            end else if (cnt_q[n] == TERM) begin
                cnt_d[n] = '0;
                sr_d[n]  = 1'b1;
            end else begin
                cnt_d[n] = cnt_q[n] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= 2'b00;
            sr_q   <= 3'b000;
            for (int n = 0; n < 3; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            addr_q <= addr_d;
            sr_q   <= sr_d;
            for (int n = 0; n < 3; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

endmodule

// File: tb/tb_router_sync.sv
// tb/tb_router_sync.sv - self-checking bench for router_sync
module tb_router_sync;

    localparam int TIMEOUT = 30;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       detect_add = 1'b0;
    logic [1:0] data_in = 2'b00;
    logic       write_enb_reg = 1'b0;
    logic [2:0] rd = 3'b000;
    logic [2:0] empty = 3'b111;
    logic [2:0] full = 3'b000;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: length of the current valid-and-unread run per port
    int         run [3];
    logic [2:0] exp_sr;
    logic [1:0] exp_addr;

    always #5 clock = ~clock;

    router_sync #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clock(clock), .reset(reset),
        .detect_add(detect_add), .data_in(data_in), .write_enb_reg(write_enb_reg),
        .read_enb_0(rd[0]), .read_enb_1(rd[1]), .read_enb_2(rd[2]),
        .empty_0(empty[0]), .empty_1(empty[1]), .empty_2(empty[2]),
        .full_0(full[0]), .full_1(full[1]), .full_2(full[2]),
        .write_enb(write_enb), .fifo_full(fifo_full),
        .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
    );

    function automatic logic [2:0] sr_vec();
        return {soft_reset_2, soft_reset_1, soft_reset_0};
    endfunction

    function automatic logic [2:0] exp_we();
        if (!write_enb_reg || exp_addr == 2'd3) return 3'b000;
        return 3'b001 << exp_addr;
    endfunction

    function automatic logic exp_full();
        if (exp_addr == 2'd3) return 1'b0;
        return full[exp_addr];
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 3; n++) run[n] = 0;
        exp_sr   = 3'b000;
        exp_addr = 2'b00;
    endtask

    // advance the model with the inputs seen at this edge, then take the edge
    task automatic step();
        for (int n = 0; n < 3; n++) begin
            if (empty[n] || rd[n]) begin
                run[n] = 0;
                exp_sr[n] = 1'b0;
            end else if (run[n] + 1 == TIMEOUT) begin
                run[n] = 0;
                exp_sr[n] = 1'b1;
            end else begin
                run[n] = run[n] + 1;
                exp_sr[n] = 1'b0;
            end
        end
        if (detect_add) exp_addr = data_in;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        empty = 3'b111; rd = 3'b000; detect_add = 1'b0; write_enb_reg = 1'b0; full = 3'b000;
        step();
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (write_enb !== 3'b000 || fifo_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_comb: write_enb=%b fifo_full=%b, required 000/0", write_enb, fifo_full);
        end
        n_checks++;
        if (sr_vec() !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_sr: soft_reset=%b, required 000", sr_vec());
        end
        reset = 1'b0;
        // port 0 will pulse while port 1 is 10 cycles into its count
        empty[0] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 21) empty[1] = 1'b0;
            step();
        end
        n_checks++;
        if (sr_vec() !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_pre_pulse: soft_reset=%b, required 001", sr_vec());
        end
        #2 reset = 1'b1;
        write_enb_reg = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (sr_vec() !== 3'b000 || write_enb !== 3'b001 || fifo_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: soft_reset=%b write_enb=%b fifo_full=%b, required 000/001/0",
                     sr_vec(), write_enb, fifo_full);
        end
        write_enb_reg = 1'b0;
        #1 reset = 1'b0;
        // both counters restart from zero: both pulse 30 edges after release
        for (int k = 1; k <= 31; k++) begin
            step();
            n_checks++;
            if (sr_vec() !== exp_sr || sr_vec() !== ((k == 30) ? 3'b011 : 3'b000)) begin
                n_fail++;
                $display("FAIL reset_restart k=%0d: soft_reset=%b, required %b", k, sr_vec(), exp_sr);
            end
        end
        idle();
    endtask

    task automatic test_steering();
        detect_add = 1'b1; data_in = 2'b10;
        step();
        detect_add = 1'b0; write_enb_reg = 1'b1;
        #1;
        n_checks++;
        if (write_enb !== 3'b100 || write_enb !== exp_we()) begin
            n_fail++;
            $display("FAIL steer_we: write_enb=%b, required 100", write_enb);
        end
        full[2] = 1'b1;
        #1;
        n_checks++;
        if (fifo_full !== 1'b1) begin
            n_fail++;
            $display("FAIL steer_full2: fifo_full=%b, required 1", fifo_full);
        end
        full[2] = 1'b0; full[0] = 1'b1;
        #1;
        n_checks++;
        if (fifo_full !== 1'b0) begin
            n_fail++;
            $display("FAIL steer_full0_ignored: fifo_full=%b, required 0", fifo_full);
        end
        idle();
    endtask

    task automatic test_invalid();
        detect_add = 1'b1; data_in = 2'b11;
        step();
        detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b111;
        #1;
        n_checks++;
        if (write_enb !== 3'b000 || fifo_full !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_addr: write_enb=%b fifo_full=%b, required 000/0", write_enb, fifo_full);
        end
        idle();
    endtask

    task automatic test_timeout();
        empty[0] = 1'b0;
        #1;
        n_checks++;
        if (vld_out_0 !== 1'b1) begin
            n_fail++;
            $display("FAIL vld_out_0: got %b, required 1", vld_out_0);
        end
        for (int k = 1; k <= 62; k++) begin
            step();
            n_checks++;
            if (soft_reset_0 !== exp_sr[0] || soft_reset_0 !== (k == 30 || k == 60)) begin
                n_fail++;
                $display("FAIL timeout k=%0d: soft_reset_0=%b, required %b", k, soft_reset_0, exp_sr[0]);
            end
        end
        idle();
    endtask

    task automatic test_read_saves();
        empty[1] = 1'b0;
        for (int k = 1; k <= 61; k++) begin
            rd[1] = (k == 29);
            step();
            n_checks++;
            if (soft_reset_1 !== exp_sr[1] || soft_reset_1 !== (k == 59)) begin
                n_fail++;
                $display("FAIL read_saves k=%0d: soft_reset_1=%b, required %b", k, soft_reset_1, exp_sr[1]);
            end
        end
        idle();
    endtask

    task automatic test_independence();
        empty = 3'b010;
        for (int k = 1; k <= 32; k++) begin
            step();
            n_checks++;
            if (sr_vec() !== exp_sr || sr_vec() !== ((k == 30) ? 3'b101 : 3'b000)) begin
                n_fail++;
                $display("FAIL independence k=%0d: soft_reset=%b, required %b", k, sr_vec(), exp_sr);
            end
        end
        idle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            for (int n = 0; n < 3; n++) begin
                empty[n] = ($urandom_range(0, 15) == 0);
                rd[n]    = ($urandom_range(0, 49) == 0);
            end
            detect_add    = ($urandom_range(0, 9) == 0);
            data_in       = 2'($urandom_range(0, 3));
            write_enb_reg = 1'($urandom_range(0, 1));
            full          = 3'($urandom_range(0, 7));
            #1;
            n_checks++;
            if (write_enb !== exp_we() || fifo_full !== exp_full() ||
                {vld_out_2, vld_out_1, vld_out_0} !== ~empty) begin
                n_fail++;
                $display("FAIL random_comb k=%0d: we=%b full=%b vld=%b, required %b/%b/%b", k,
                         write_enb, fifo_full, {vld_out_2, vld_out_1, vld_out_0},
                         exp_we(), exp_full(), ~empty);
            end
            step();
            n_checks++;
            if (sr_vec() !== exp_sr) begin
                n_fail++;
                $display("FAIL random_sr k=%0d: soft_reset=%b, required %b", k, sr_vec(), exp_sr);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_steering();
        test_invalid();
        test_timeout();
        test_read_saves();
        test_independence();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
